// File: rtl/grain_prog_pkg.sv
// Shared types and defaults for the configuration-chain loader.
// Holds the loader state encoding and the default bitstream word width.
package grain_prog_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } loader_state_t;

  localparam int DEFAULT_WORD_W    = 8;
  localparam int DEFAULT_CHAIN_LEN = 64;

endpackage

// File: rtl/prog_word_shifter.sv
// Parallel-in serial-out word register for the chain loader: loads a word,
// shifts it out LSB first and tracks how many bits remain in the word.
module prog_word_shifter
  import grain_prog_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic              bit_out,
  output logic              last,
  output logic              empty
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] shreg_reg;
  logic [CNT_W-1:0]  cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else if (load) begin
      shreg_reg <= load_data;
      cnt_reg   <= CNT_W'(WORD_W);
    end else if (shift && (cnt_reg != '0)) begin
      shreg_reg <= shreg_reg >> 1;
      cnt_reg   <= cnt_reg - CNT_W'(1);
    end
  end

  assign bit_out = shreg_reg[0];
  assign last    = (cnt_reg == CNT_W'(1));
  assign empty   = (cnt_reg == '0);

endmodule

// File: rtl/prog_chain_loader.sv
// Serialises a word-oriented bitstream into the prog_mux configuration chain,
// emitting exactly CHAIN_LEN shift cycles. Optional readback: PROG_LOADER_READBACK_EN.
module prog_chain_loader
  import grain_prog_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int WORD_W    = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              prog_en,
  output logic              prog_in,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int BL_W = $clog2(CHAIN_LEN + 1);

  loader_state_t   state_reg;
  logic [BL_W-1:0] bits_left_reg;
  logic            prog_en_reg;
  logic            busy_reg;
  logic            done_reg;

  logic word_load;
  logic word_shift;
  logic word_bit;
  logic word_last;
  logic word_empty;

  assign wr_ready   = (state_reg == FETCH);
  assign word_load  = wr_ready & wr_valid;
  assign word_shift = (state_reg == SHIFT) & ~word_empty;

  prog_word_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (word_load),
    .load_data (wr_data),
    .shift     (word_shift),
    .bit_out   (word_bit),
    .last      (word_last),
    .empty     (word_empty)
  );

  // prog_en is set on entry to SHIFT so it is high exactly in SHIFT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bits_left_reg <= '0;
      prog_en_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= FETCH;
            busy_reg      <= 1'b1;
            bits_left_reg <= BL_W'(CHAIN_LEN);
          end
        end
        FETCH: begin
          if (wr_valid) begin
            state_reg   <= SHIFT;
            prog_en_reg <= 1'b1;
          end
        end
        SHIFT: begin
          bits_left_reg <= bits_left_reg - BL_W'(1);
          if (bits_left_reg == BL_W'(1)) begin
            state_reg   <= FINISH;
            prog_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
          end else if (word_last) begin
            state_reg   <= FETCH;
            prog_en_reg <= 1'b0;
          end
        end
        FINISH: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          prog_en_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign prog_en = prog_en_reg;
  assign prog_in = word_bit;
  assign busy    = busy_reg;
  assign done    = done_reg;

`ifdef PROG_LOADER_READBACK_EN
  localparam int RC_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] rb_pack_reg;
  logic [WORD_W-1:0] rb_pack_next;
  logic [WORD_W-1:0] rb_data_reg;
  logic [RC_W-1:0]   rb_cnt_reg;
  logic              rb_valid_reg;

  // The chain tail is sampled while it is being shifted, so samples arrive tail first.
  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_rb_bit
    assign rb_pack_next[gi] = (rb_cnt_reg == RC_W'(gi)) ? prog_out : rb_pack_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_pack_reg  <= '0;
      rb_data_reg  <= '0;
      rb_cnt_reg   <= '0;
      rb_valid_reg <= 1'b0;
    end else begin
      rb_valid_reg <= 1'b0;
      if (prog_en_reg) begin
        if (rb_cnt_reg == RC_W'(WORD_W - 1)) begin
          rb_data_reg  <= rb_pack_next;
          rb_valid_reg <= 1'b1;
          rb_pack_reg  <= '0;
          rb_cnt_reg   <= '0;
        end else begin
          rb_pack_reg <= rb_pack_next;
          rb_cnt_reg  <= rb_cnt_reg + RC_W'(1);
        end
      end else if ((state_reg == FINISH) && (rb_cnt_reg != '0)) begin
        rb_data_reg  <= rb_pack_reg;
        rb_valid_reg <= 1'b1;
        rb_pack_reg  <= '0;
        rb_cnt_reg   <= '0;
      end
    end
  end

  assign rb_data  = rb_data_reg;
  assign rb_valid = rb_valid_reg;
`else
  logic prog_out_unused;
  assign prog_out_unused = prog_out;
  assign rb_data         = '0;
  assign rb_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_chain_loader.sv
// Bench for prog_chain_loader: a 16-bit and a 12-bit chain fed from vector
// tables, hand sequences and random loads, checked against a fabric chain model.
module tb_prog_chain_loader;

  localparam int WW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    start_v    = 2'b00;
  logic [1:0]    wr_valid_v = 2'b00;
  logic [WW-1:0] wr_data_v [2];
  wire  [1:0]    wr_ready_v, prog_en_v, prog_in_v, prog_out_v, busy_v, done_v, rb_valid_v;
  wire  [WW-1:0] rb_data0, rb_data1;

  prog_chain_loader #(.CHAIN_LEN(16), .WORD_W(WW)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .wr_data(wr_data_v[0]), .wr_valid(wr_valid_v[0]),
    .wr_ready(wr_ready_v[0]), .prog_en(prog_en_v[0]), .prog_in(prog_in_v[0]), .prog_out(prog_out_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .rb_data(rb_data0), .rb_valid(rb_valid_v[0]));

  prog_chain_loader #(.CHAIN_LEN(12), .WORD_W(WW)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .wr_data(wr_data_v[1]), .wr_valid(wr_valid_v[1]),
    .wr_ready(wr_ready_v[1]), .prog_en(prog_en_v[1]), .prog_in(prog_in_v[1]), .prog_out(prog_out_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .rb_data(rb_data1), .rb_valid(rb_valid_v[1]));

  // Fabric model: cell 0 is the first cell, the highest index is the tail.
  logic [15:0] chain_a = 16'h0;
  logic [15:0] chain_b = 16'h0;
  always @(posedge clk) begin
    if (prog_en_v[0]) chain_a <= {chain_a[14:0], prog_in_v[0]};
    if (prog_en_v[1]) chain_b <= {4'h0, chain_b[10:0], prog_in_v[1]};
  end
  assign prog_out_v = {chain_b[11], chain_a[15]};

  int          en_cnt   [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          busy_cnt [2] = '{0, 0};
  int          rb_stray = 0;
  logic [31:0] seq_cap  [2] = '{32'h0, 32'h0};
  logic [7:0]  rb_q0[$];
  logic [7:0]  rb_q1[$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (prog_en_v[d]) begin
        en_cnt[d]  <= en_cnt[d] + 1;
        seq_cap[d] <= {prog_in_v[d], seq_cap[d][31:1]};
      end
      if (done_v[d]) done_cnt[d] <= done_cnt[d] + 1;
      if (busy_v[d]) busy_cnt[d] <= busy_cnt[d] + 1;
    end
    if (rb_valid_v[0]) rb_q0.push_back(rb_data0);
    if (rb_valid_v[1]) rb_q1.push_back(rb_data1);
    if ((rb_valid_v != 2'b00) || (rb_data0 != 8'h0) || (rb_data1 != 8'h0)) rb_stray <= rb_stray + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int len_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  // Stream bit k must end up k cells away from the tail.
  function automatic logic [15:0] exp_chain(input logic [15:0] seq, input int len);
    logic [15:0] c;
    c = '0;
    for (int k = 0; k < len; k++) c[len-1-k] = seq[k];
    return c;
  endfunction

  function automatic logic [15:0] chain_of(input int d);
    return (d == 0) ? chain_a : chain_b;
  endfunction

  task automatic do_start(input int d);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  task automatic send_word(input int d, input logic [7:0] w, input int gap, input bit spam, input string tag);
    int stall;
    bit ok;
    stall = 0;
    ok    = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (spam) start_v[d] = ($urandom_range(0, 2) == 0);
      if (wr_ready_v[d]) begin
        if (stall >= gap) begin
          wr_data_v[d]  = w;
          wr_valid_v[d] = 1'b1;
          ok            = 1'b1;
        end else begin
          stall++;
        end
      end
    end
    @(posedge clk); #1;
    wr_valid_v[d] = 1'b0;
    start_v[d]    = 1'b0;
    chk({tag, "_word_accepted"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int d, input string tag);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (done_v[d]) begin
        ok = 1'b1;
        chk({tag, "_busy_at_done"}, 32'(busy_v[d]), 32'd0);
      end
    end
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input int d, input logic [7:0] w0, input logic [7:0] w1, input int gap,
                          input bit spam, input logic [15:0] exp_seq, input int exp_en,
                          input int exp_busy, input string tag);
    int          en0, dn0, bz0, rb0, len;
    logic [15:0] prev_tail, pre_chain, got_seq;
    len       = len_of(d);
    en0       = en_cnt[d];
    dn0       = done_cnt[d];
    bz0       = busy_cnt[d];
    rb0       = (d == 0) ? rb_q0.size() : rb_q1.size();
    pre_chain = chain_of(d);
    prev_tail = '0;
    for (int k = 0; k < len; k++) prev_tail[k] = pre_chain[len-1-k];
    do_start(d);
    send_word(d, w0, gap, spam, tag);
    send_word(d, w1, gap, spam, tag);
    wait_done(d, tag);
    repeat (2) begin @(posedge clk); #1; end
    got_seq = 16'(seq_cap[d] >> (32 - len));
    chk({tag, "_en_cycles"}, 32'(en_cnt[d] - en0), 32'(exp_en));
    chk({tag, "_done_pulses"}, 32'(done_cnt[d] - dn0), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt[d] - bz0), 32'(exp_busy));
    chk({tag, "_prog_in_seq"}, 32'(got_seq), 32'(exp_seq));
    chk({tag, "_chain"}, 32'(chain_of(d)), 32'(exp_chain(exp_seq, len)));
`ifdef PROG_LOADER_READBACK_EN
    begin
      int n;
      n = ((d == 0) ? rb_q0.size() : rb_q1.size()) - rb0;
      chk({tag, "_rb_count"}, 32'(n), 32'd2);
      if (n >= 2) begin
        chk({tag, "_rb_word0"}, 32'((d == 0) ? rb_q0[rb0] : rb_q1[rb0]), 32'(prev_tail[7:0]));
        chk({tag, "_rb_word1"}, 32'((d == 0) ? rb_q0[rb0+1] : rb_q1[rb0+1]), 32'(prev_tail[15:8]));
      end
    end
`else
    chk({tag, "_rb_none"}, 32'(((d == 0) ? rb_q0.size() : rb_q1.size()) - rb0), 32'd0);
`endif
    $display("load %s: dut=%0d words=%02h,%02h gap=%0d seq=%04h chain=%04h", tag, d, w0, w1, gap,
             got_seq, chain_of(d));
  endtask

  typedef struct {
    int         d;
    logic [7:0] w0;
    logic [7:0] w1;
    int         gap;
    logic [15:0] exp_seq;
    int         exp_en;
    int         exp_busy;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_data_v[0] = '0;
    wr_data_v[1] = '0;
    // Busy cycles per load = chain length + one FETCH and `gap` stall cycles per word.
    vecs[0] = '{0, 8'hA5, 8'h3C, 0, 16'h3CA5, 16, 18};
    vecs[1] = '{0, 8'hA5, 8'h3C, 3, 16'h3CA5, 16, 24};
    vecs[2] = '{0, 8'hFF, 8'h00, 1, 16'h00FF, 16, 20};
    vecs[3] = '{0, 8'h01, 8'h80, 2, 16'h8001, 16, 22};
    vecs[4] = '{1, 8'h00, 8'h00, 0, 16'h0000, 12, 14};
    vecs[5] = '{1, 8'hFF, 8'hFF, 0, 16'h0FFF, 12, 14};
    vecs[6] = '{1, 8'h00, 8'hF0, 1, 16'h0000, 12, 16};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_prog_en", 32'(prog_en_v), 32'd0);
    chk("reset_prog_in", 32'(prog_in_v), 32'd0);
    chk("reset_busy", 32'(busy_v), 32'd0);
    chk("reset_done", 32'(done_v), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready_v), 32'd0);
    chk("reset_rb_valid", 32'(rb_valid_v), 32'd0);
    chk("reset_rb_data", 32'({rb_data1, rb_data0}), 32'd0);
    $display("reset: prog_en=%b busy=%b wr_ready=%b", prog_en_v, busy_v, wr_ready_v);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_load(vecs[i].d, vecs[i].w0, vecs[i].w1, vecs[i].gap, 1'b0, vecs[i].exp_seq,
               vecs[i].exp_en, vecs[i].exp_busy, $sformatf("vec%0d", i));
    end

    // start and wr_valid together in IDLE: the word waits for FETCH.
    begin
      int dn0;
      dn0 = done_cnt[0];
      start_v[0] = 1'b1; wr_valid_v[0] = 1'b1; wr_data_v[0] = 8'hA5;
      @(negedge clk);
      chk("same_cycle_ready_idle", 32'(wr_ready_v[0]), 32'd0);
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(negedge clk);
      chk("same_cycle_ready_fetch", 32'(wr_ready_v[0]), 32'd1);
      chk("same_cycle_busy", 32'(busy_v[0]), 32'd1);
      chk("same_cycle_no_shift", 32'(prog_en_v[0]), 32'd0);
      @(posedge clk); #1;
      wr_valid_v[0] = 1'b0;
      @(negedge clk);
      chk("same_cycle_first_bit", 32'({prog_en_v[0], prog_in_v[0]}), 32'b11);
      @(posedge clk); #1;
      send_word(0, 8'h3C, 0, 1'b0, "same_cycle");
      wait_done(0, "same_cycle");
      chk("same_cycle_chain", 32'(chain_a), 32'(exp_chain(16'h3CA5, 16)));
      chk("same_cycle_done_pulses", 32'(done_cnt[0] - dn0), 32'd1);
      $display("same-cycle start: chain=%04h", chain_a);
    end

    // Reset during the fifth shift, then a clean reload.
    begin
      int en0;
      bit hit;
      en0 = en_cnt[0];
      hit = 1'b0;
      do_start(0);
      send_word(0, 8'h5A, 0, 1'b0, "rst_mid");
      for (int t = 0; t < 50 && !hit; t++) begin
        @(negedge clk); #1;
        if (en_cnt[0] - en0 == 5) hit = 1'b1;
      end
      chk("rst_mid_reached_5", 32'(hit), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_prog_en", 32'(prog_en_v[0]), 32'd0);
      chk("rst_mid_busy", 32'(busy_v[0]), 32'd0);
      chk("rst_mid_wr_ready", 32'(wr_ready_v[0]), 32'd0);
      $display("reset mid-load: prog_en=%b busy=%b wr_ready=%b", prog_en_v[0], busy_v[0], wr_ready_v[0]);
      @(posedge clk); #1;
      run_load(0, 8'hA5, 8'h3C, 0, 1'b0, 16'h3CA5, 16, 18, "rst_reload");
    end

    // Random loads with random stalls and ignored start pulses.
    for (int i = 0; i < 24; i++) begin
      int          d, gap, len;
      logic [7:0]  w0, w1;
      logic [15:0] seq, mask;
      d    = $urandom_range(0, 1);
      gap  = $urandom_range(0, 3);
      w0   = 8'($urandom);
      w1   = 8'($urandom);
      len  = len_of(d);
      mask = 16'((32'h1 << len) - 1);
      seq  = {w1, w0} & mask;
      run_load(d, w0, w1, gap, 1'b1, seq, len, len + 2 + 2 * gap, $sformatf("rnd%0d", i));
    end

`ifndef PROG_LOADER_READBACK_EN
    chk("rb_outputs_idle", 32'(rb_stray), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
